// File: rtl/streaming_fifo_pkg.sv
// rtl/streaming_fifo_pkg.sv - shared defaults and width helper for streaming_fifo_wm
package streaming_fifo_pkg;

  localparam int DEF_WIDTH     = 72;
  localparam int DEF_DEPTH     = 1600;
  localparam int DEF_AF_THRESH = 1536;
  localparam int DEF_AE_THRESH = 64;

  // Bits needed to hold every value 0..n (at least 1).
  function automatic int clog2_cnt(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << r) <= n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/streaming_fifo_wm_if.sv
// rtl/streaming_fifo_wm_if.sv - one stream channel (TDATA/TVALID/TREADY)
interface streaming_fifo_wm_if
  import streaming_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic [WIDTH-1:0] TDATA;
  logic             TVALID;
  logic             TREADY;

  modport master (output TDATA, output TVALID, input TREADY);
  modport slave  (input TDATA, input TVALID, output TREADY);
endinterface

// File: rtl/streaming_fifo_wm_ram.sv
// rtl/streaming_fifo_wm_ram.sv - simple dual-port RAM with one-cycle registered read
module streaming_fifo_wm_ram
  import streaming_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH - 1,
  parameter int AW    = clog2_cnt(DEPTH - 1)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  // No reset on the array or read register so block/ultra RAM can be inferred.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/streaming_fifo_wm.sv
// rtl/streaming_fifo_wm.sv - any-depth FWFT stream FIFO with high-water mark and level flags
module streaming_fifo_wm
  import streaming_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEF_AF_THRESH,
  parameter int AE_THRESH = DEF_AE_THRESH,
  localparam int CW       = clog2_cnt(DEPTH)
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  streaming_fifo_wm_if.slave        in0_V,
  streaming_fifo_wm_if.master       out_V,
  input  logic                      maxcount_clr,
  output logic [CW-1:0]             count,
  output logic [CW-1:0]             maxcount,
  output logic                      almost_full,
  output logic                      almost_empty
);
  localparam int PW                = clog2_cnt(DEPTH - 2);
  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 2);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             out_valid, src_is_ram, in_ready;
  logic [WIDTH-1:0] byp_data, ram_rd_data;
  logic             push, pop, load, ram_empty, use_bypass, ram_wr, ram_rd;
  logic [CW-1:0]    count_next;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign push       = in0_V.TVALID & in_ready;
  assign pop        = out_valid & out_V.TREADY;
  assign load       = ~out_valid | pop;
  // RAM occupancy is count minus the word held in the output register.
  assign ram_empty  = (count == CW'(out_valid));
  assign ram_rd     = load & ~ram_empty;
  assign use_bypass = load & ram_empty & push;
  assign ram_wr     = push & ~use_bypass;

  always_comb begin
    count_next = count;
    if (push & ~pop)      count_next = count + CW'(1);
    else if (pop & ~push) count_next = count - CW'(1);
  end

  assign in0_V.TREADY = in_ready;
  assign out_V.TVALID = out_valid;
  assign out_V.TDATA  = src_is_ram ? ram_rd_data : byp_data;
  assign almost_full  = (count >= CW'(AF_THRESH));
  assign almost_empty = (count <= CW'(AE_THRESH));

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      count      <= '0;
      maxcount   <= '0;
      in_ready   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      out_valid  <= 1'b0;
      src_is_ram <= 1'b0;
      byp_data   <= '0;
    end else begin
      count    <= count_next;
      in_ready <= (count_next < CNT_DEPTH);
      maxcount <= (maxcount_clr || count_next > maxcount) ? count_next : maxcount;
      if (ram_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (ram_rd) rd_ptr <= ptr_inc(rd_ptr);
      if (load) begin
        out_valid <= ram_rd | use_bypass;
        if (ram_rd | use_bypass) src_is_ram <= ram_rd;
      end
      if (use_bypass) byp_data <= in0_V.TDATA;
    end
  end

  streaming_fifo_wm_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH - 1),
    .AW    (PW)
  ) u_ram (
    .clk     (ap_clk),
    .wr_en   (ram_wr),
    .wr_addr (wr_ptr),
    .wr_data (in0_V.TDATA),
    .rd_en   (ram_rd),
    .rd_addr (rd_ptr),
    .rd_data (ram_rd_data)
  );
endmodule

// File: tb/tb_streaming_fifo_wm.sv
// tb/tb_streaming_fifo_wm.sv - self-checking bench for streaming_fifo_wm at depths 4, 5, 8, 1600
module tb_streaming_fifo_wm;
  localparam int W  = 72;
  localparam int NI = 4;

  function automatic int dep_of(input int i);
    case (i)
      0: return 4;
      1: return 5;
      2: return 8;
      default: return 1600;
    endcase
  endfunction
  function automatic int af_of(input int i);
    case (i)
      0: return 4;
      1: return 5;
      2: return 7;
      default: return 1536;
    endcase
  endfunction
  function automatic int ae_of(input int i);
    case (i)
      0: return 1;
      1: return 1;
      2: return 2;
      default: return 64;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         iv   [NI];
  logic [W-1:0] id   [NI];
  logic         ordy [NI];
  logic         clr  [NI];

  int           cnt_o  [NI];
  int           maxc_o [NI];
  logic         af_o   [NI];
  logic         ae_o   [NI];
  logic         tr_o   [NI];
  logic         tv_o   [NI];
  logic [W-1:0] td_o   [NI];

  genvar g;
  for (g = 0; g < NI; g++) begin : g_inst
    localparam int D   = dep_of(g);
    localparam int CWL = $clog2(D + 1);
    streaming_fifo_wm_if #(.WIDTH(W)) in_if ();
    streaming_fifo_wm_if #(.WIDTH(W)) out_if ();
    logic [CWL-1:0] cnt, mx;
    logic           af, ae;

    assign in_if.TVALID  = iv[g];
    assign in_if.TDATA   = id[g];
    assign out_if.TREADY = ordy[g];

    streaming_fifo_wm #(
      .WIDTH(W), .DEPTH(D), .AF_THRESH(af_of(g)), .AE_THRESH(ae_of(g))
    ) u_dut (
      .ap_clk       (clk),
      .ap_rst_n     (rst_n),
      .in0_V        (in_if),
      .out_V        (out_if),
      .maxcount_clr (clr[g]),
      .count        (cnt),
      .maxcount     (mx),
      .almost_full  (af),
      .almost_empty (ae)
    );

    assign cnt_o[g]  = int'(cnt);
    assign maxc_o[g] = int'(mx);
    assign af_o[g]   = af;
    assign ae_o[g]   = ae;
    assign tr_o[g]   = in_if.TREADY;
    assign tv_o[g]   = out_if.TVALID;
    assign td_o[g]   = out_if.TDATA;
  end

  // Reference: a queue per FIFO; the head is what must be presented downstream.
  logic [W-1:0] mq [NI][$];
  int           mmax    [NI];
  logic         mtr     [NI];
  int           mpushed [NI];
  int           mpopped [NI];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        mq[i].delete();
        mmax[i] <= 0;
        mtr[i]  <= 1'b0;
      end else begin
        int c;
        if (mq[i].size() > 0 && ordy[i]) begin
          void'(mq[i].pop_front());
          mpopped[i] <= mpopped[i] + 1;
        end
        if (iv[i] && mtr[i]) begin
          mq[i].push_back(id[i]);
          mpushed[i] <= mpushed[i] + 1;
        end
        c = mq[i].size();
        mmax[i] <= (clr[i] || c > mmax[i]) ? c : mmax[i];
        mtr[i]  <= (c < dep_of(i));
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int idx, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        chk("rst_count", i, W'(cnt_o[i]), W'(0));
        chk("rst_maxcount", i, W'(maxc_o[i]), W'(0));
        chk("rst_tvalid", i, W'(tv_o[i]), W'(0));
        chk("rst_tdata", i, td_o[i], W'(0));
        chk("rst_tready", i, W'(tr_o[i]), W'(0));
        chk("rst_almost_empty", i, W'(ae_o[i]), W'(1));
        chk("rst_almost_full", i, W'(af_o[i]), W'(0));
      end else begin
        int sz;
        sz = mq[i].size();
        chk("count", i, W'(cnt_o[i]), W'(sz));
        chk("count_le_depth", i, W'(cnt_o[i] <= dep_of(i)), W'(1));
        chk("tvalid", i, W'(tv_o[i]), W'(sz > 0));
        if (sz > 0) chk("tdata", i, td_o[i], mq[i][0]);
        chk("tready", i, W'(tr_o[i]), W'(mtr[i]));
        chk("maxcount", i, W'(maxc_o[i]), W'(mmax[i]));
        chk("almost_full", i, W'(af_o[i]), W'(sz >= af_of(i)));
        chk("almost_empty", i, W'(ae_o[i]), W'(sz <= ae_of(i)));
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    logic [95:0] r;
    int n;
    for (int i = 0; i < NI; i++) begin
      iv[i] = 1'b0; id[i] = '0; ordy[i] = 1'b0; clr[i] = 1'b0;
      mpushed[i] = 0; mpopped[i] = 0;
    end
    repeat (3) cyc();

    // Reset release: TREADY rises on the first clock, FIFO reports empty.
    rst_n = 1'b1;
    cyc();
    chk("t1_tready", 0, W'(tr_o[0]), W'(1));
    chk("t1_count", 0, W'(cnt_o[0]), W'(0));
    chk("t1_almost_empty", 0, W'(ae_o[0]), W'(1));
    chk("t1_tvalid", 0, W'(tv_o[0]), W'(0));

    // One word into an empty FIFO, held under backpressure.
    iv[0] = 1'b1; id[0] = W'(72'hA1);
    cyc();
    iv[0] = 1'b0;
    chk("t2_tvalid", 0, W'(tv_o[0]), W'(1));
    chk("t2_tdata", 0, td_o[0], W'(72'hA1));
    chk("t2_count", 0, W'(cnt_o[0]), W'(1));
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("t2_hold_tdata", 0, td_o[0], W'(72'hA1));
    end
    ordy[0] = 1'b1;
    cyc();
    ordy[0] = 1'b0;
    chk("t2_drained", 0, W'(cnt_o[0]), W'(0));

    // Fill DEPTH=5 completely, attempt an extra push, then free one slot.
    iv[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      id[1] = W'(16 + k);
      cyc();
    end
    chk("t3_count_full", 1, W'(cnt_o[1]), W'(5));
    chk("t3_tready_full", 1, W'(tr_o[1]), W'(0));
    chk("t3_almost_full", 1, W'(af_o[1]), W'(1));
    id[1] = W'(8'hFF);
    cyc();
    iv[1] = 1'b0;
    chk("t3_no_overflow", 1, W'(cnt_o[1]), W'(5));
    ordy[1] = 1'b1;
    cyc();
    ordy[1] = 1'b0;
    chk("t3_tready_rise", 1, W'(tr_o[1]), W'(1));
    chk("t3_count_after_pop", 1, W'(cnt_o[1]), W'(4));
    chk("t3_next_head", 1, td_o[1], W'(8'h11));

    // Steady push&pop at occupancy 4 walks both pointers around the 4-entry RAM.
    iv[1] = 1'b1; ordy[1] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      id[1] = W'(16'h100 + k);
      cyc();
      chk("t5_count_const", 1, W'(cnt_o[1]), W'(4));
    end
    iv[1] = 1'b0; ordy[1] = 1'b0;
    cyc();
    chk("t5_head_after_wrap", 1, td_o[1], W'(16'h110));
    ordy[1] = 1'b1;
    repeat (4) cyc();
    ordy[1] = 1'b0;
    chk("t5_drained", 1, W'(cnt_o[1]), W'(0));

    // Random traffic at DEPTH=1600: slow reader first to reach full, then mostly flowing.
    for (int k = 0; k < 5000; k++) begin
      r = {$urandom(), $urandom(), $urandom()};
      iv[3] = ($urandom_range(0, 9) < 8);
      id[3] = r[W-1:0];
      ordy[3] = ($urandom_range(0, 9) < 3);
      cyc();
    end
    chk("t4_reached_full", 3, W'(maxc_o[3]), W'(1600));
    n = 0;
    while (mpushed[3] < 10000 && n < 30000) begin
      r = {$urandom(), $urandom(), $urandom()};
      iv[3] = ($urandom_range(0, 9) < 8);
      id[3] = r[W-1:0];
      ordy[3] = ($urandom_range(0, 9) < 9);
      cyc();
      n++;
    end
    iv[3] = 1'b0; ordy[3] = 1'b1;
    n = 0;
    while (mq[3].size() > 0 && n < 3000) begin
      cyc();
      n++;
    end
    ordy[3] = 1'b0;
    cyc();
    chk("t4_enough_words", 3, W'(mpushed[3] >= 10000), W'(1));
    chk("t4_all_out", 3, W'(mpopped[3]), W'(mpushed[3]));
    chk("t4_drained", 3, W'(cnt_o[3]), W'(0));

    // High-water mark at DEPTH=8, clear, then reset mid-stream.
    iv[2] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      id[2] = W'(16'h200 + k);
      cyc();
    end
    iv[2] = 1'b0;
    chk("t6_count7", 2, W'(cnt_o[2]), W'(7));
    chk("t6_max7", 2, W'(maxc_o[2]), W'(7));
    chk("t6_almost_full", 2, W'(af_o[2]), W'(1));
    ordy[2] = 1'b1;
    repeat (5) cyc();
    ordy[2] = 1'b0;
    chk("t6_count2", 2, W'(cnt_o[2]), W'(2));
    chk("t6_max_held", 2, W'(maxc_o[2]), W'(7));
    chk("t6_almost_empty", 2, W'(ae_o[2]), W'(1));
    clr[2] = 1'b1;
    cyc();
    clr[2] = 1'b0;
    chk("t6_max_cleared", 2, W'(maxc_o[2]), W'(2));
    iv[2] = 1'b1; ordy[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      id[2] = W'(16'h300 + k);
      cyc();
    end
    rst_n = 1'b0;
    cyc();
    chk("t6_rst_count", 2, W'(cnt_o[2]), W'(0));
    chk("t6_rst_tvalid", 2, W'(tv_o[2]), W'(0));
    chk("t6_rst_max", 2, W'(maxc_o[2]), W'(0));
    chk("t6_rst_tready", 2, W'(tr_o[2]), W'(0));
    iv[2] = 1'b0; ordy[2] = 1'b0;
    rst_n = 1'b1;
    cyc();
    chk("t6_post_tready", 2, W'(tr_o[2]), W'(1));
    iv[2] = 1'b1; id[2] = W'(8'h3C);
    cyc();
    iv[2] = 1'b0;
    chk("t6_post_tdata", 2, td_o[2], W'(8'h3C));
    chk("t6_post_count", 2, W'(cnt_o[2]), W'(1));
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
